// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared runtime-monitor types and constants
package ariane_pkg;

  localparam int NUM_LANES         = 5;
  localparam int NUM_EVENTS        = 10;
  localparam int NUM_MONITORED_INS = 2;
  localparam int RM_CNT_W          = 8;

  localparam int RM_LANE_IDX_W = $clog2(NUM_LANES);
  localparam int RM_ITYPE_W    = $clog2(NUM_MONITORED_INS);

  // Per-event routing control produced by the event detectors
  typedef struct packed {
    logic [RM_LANE_IDX_W-1:0] lane0;
    logic [RM_LANE_IDX_W-1:0] lane1;
    logic [RM_ITYPE_W-1:0]    itype;
    logic                     probe_val;
    logic                     reset_lane;
    logic                     two_lane;
  } lane_ctrl;

  typedef enum logic {
    RM_LANE_EMPTY = 1'b0,
    RM_LANE_FULL  = 1'b1
  } rm_lane_state_e;

endpackage

// File: rtl/rm_lane_buffer.sv
// rtl/rm_lane_buffer.sv - per-lane sticky hit buffer with handshake and collision counter
module rm_lane_buffer #(
  parameter int NUM_MONITORED_INS = 2,
  parameter int NUM_EVENTS        = 10,
  parameter int CNT_W             = 8
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic [NUM_MONITORED_INS-1:0][NUM_EVENTS-1:0] hit_i,
  input  logic                                         rst_req_i,
  input  logic                                         clr_cnt_i,
  input  logic                                         ready_i,
  output logic                                         valid_o,
  output logic [NUM_MONITORED_INS-1:0][NUM_EVENTS-1:0] vector_o,
  output logic                                         reset_o,
  output logic [CNT_W-1:0]                             coll_cnt_o
);
  import ariane_pkg::*;

  rm_lane_state_e                              state_q;
  logic [NUM_MONITORED_INS-1:0][NUM_EVENTS-1:0] buf_q;
  logic                                        reset_q;
  logic [CNT_W-1:0]                            cnt_q;
  logic [CNT_W-1:0]                            cnt_d;
  logic                                        coll_hit;

  // A collision is a hit landing on a bit already pending while the checker stalls;
  // a lane reset in the same cycle discards the hits, so nothing is counted then.
  assign coll_hit = !rst_req_i && (state_q == RM_LANE_FULL) && !ready_i &&
                    (|(buf_q & hit_i));

  // Saturating collision counter next-state, clear beats increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (coll_hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // EMPTY/FULL state machine owning the sticky buffer and the reset pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RM_LANE_EMPTY;
      buf_q   <= '0;
      reset_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      reset_q <= rst_req_i;
      cnt_q   <= cnt_d;
      if (rst_req_i) begin
        state_q <= RM_LANE_EMPTY;
        buf_q   <= '0;
      end else begin
        case (state_q)
          RM_LANE_EMPTY: begin
            if (|hit_i) begin
              buf_q   <= hit_i;
              state_q <= RM_LANE_FULL;
            end
          end
          RM_LANE_FULL: begin
            if (ready_i) begin
              buf_q   <= hit_i;
              state_q <= (|hit_i) ? RM_LANE_FULL : RM_LANE_EMPTY;
            end else begin
              buf_q <= buf_q | hit_i;
            end
          end
          default: begin
            state_q <= RM_LANE_EMPTY;
            buf_q   <= '0;
          end
        endcase
      end
    end
  end

  assign valid_o    = (state_q == RM_LANE_FULL);
  assign vector_o   = buf_q;
  assign reset_o    = reset_q;
  assign coll_cnt_o = cnt_q;

endmodule

// File: rtl/rm_event_router_q.sv
// rtl/rm_event_router_q.sv - registered flow-controlled probe event router
module rm_event_router_q #(
  parameter int NUM_LANES         = ariane_pkg::NUM_LANES,
  parameter int NUM_EVENTS        = ariane_pkg::NUM_EVENTS,
  parameter int NUM_MONITORED_INS = ariane_pkg::NUM_MONITORED_INS,
  parameter int CNT_W             = ariane_pkg::RM_CNT_W
) (
  input  logic                                                          clk_i,
  input  logic                                                          rst_ni,
  input  ariane_pkg::lane_ctrl [NUM_EVENTS-1:0]                         events_i,
  input  logic                                                          dual_mode_i,
  input  logic                                                          clr_cnt_i,
  input  logic [NUM_LANES-1:0]                                          lane_ready_i,
  output logic [NUM_LANES-1:0]                                          lane_valid_o,
  output logic [NUM_LANES-1:0][NUM_MONITORED_INS-1:0][NUM_EVENTS-1:0]   lane_vector_o,
  output logic [NUM_LANES-1:0]                                          lane_reset_o,
  output logic [NUM_LANES-1:0][CNT_W-1:0]                               lane_collision_cnt_o,
  output logic [CNT_W-1:0]                                              drop_cnt_o
);
  import ariane_pkg::*;

  logic [NUM_LANES-1:0][NUM_MONITORED_INS-1:0][NUM_EVENTS-1:0] hit;
  logic [NUM_LANES-1:0]                                        rst_req;
  logic                                                        drop_any;
  logic [CNT_W-1:0]                                            drop_cnt_q;

  // Route every active event to its lane(s); target 0 is lane0, target 1 is lane1
  always_comb begin
    hit      = '0;
    rst_req  = '0;
    drop_any = 1'b0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      for (int t = 0; t < 2; t++) begin
        logic                     tgt_en;
        logic [RM_LANE_IDX_W-1:0] lid;
        tgt_en = (t == 0) ? (!events_i[i].two_lane || dual_mode_i) : events_i[i].two_lane;
        lid    = (t == 0) ? events_i[i].lane0 : events_i[i].lane1;
        if (tgt_en && (events_i[i].probe_val || events_i[i].reset_lane)) begin
          if ((int'(lid) >= NUM_LANES) || (int'(events_i[i].itype) >= NUM_MONITORED_INS)) begin
            drop_any = 1'b1;
          end else begin
            if (events_i[i].probe_val) begin
              hit[lid][events_i[i].itype][i] = 1'b1;
            end
            if (events_i[i].reset_lane) begin
              rst_req[lid] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Saturating count of cycles that dropped at least one target, clear wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else if (clr_cnt_i) begin
      drop_cnt_q <= '0;
    end else if (drop_any && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign drop_cnt_o = drop_cnt_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    rm_lane_buffer #(
      .NUM_MONITORED_INS (NUM_MONITORED_INS),
      .NUM_EVENTS        (NUM_EVENTS),
      .CNT_W             (CNT_W)
    ) u_lane (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .hit_i      (hit[l]),
      .rst_req_i  (rst_req[l]),
      .clr_cnt_i  (clr_cnt_i),
      .ready_i    (lane_ready_i[l]),
      .valid_o    (lane_valid_o[l]),
      .vector_o   (lane_vector_o[l]),
      .reset_o    (lane_reset_o[l]),
      .coll_cnt_o (lane_collision_cnt_o[l])
    );
  end

endmodule

// File: tb/tb_rm_event_router_q.sv
// tb/tb_rm_event_router_q.sv - scoreboard bench for rm_event_router_q
module tb_rm_event_router_q;
  import ariane_pkg::*;

  localparam int NL = 5;
  localparam int NE = 10;
  localparam int NI = 2;
  localparam int CW = 8;
  localparam int VW = NI * NE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lane_ctrl [NE-1:0]                  events;
  logic                               dual;
  logic                               clr;
  logic [NL-1:0]                      ready;
  logic [NL-1:0]                      lane_valid;
  logic [NL-1:0][NI-1:0][NE-1:0]      lane_vector;
  logic [NL-1:0]                      lane_reset;
  logic [NL-1:0][CW-1:0]              coll_cnt;
  logic [CW-1:0]                      drop_cnt;

  rm_event_router_q #(
    .NUM_LANES         (NL),
    .NUM_EVENTS        (NE),
    .NUM_MONITORED_INS (NI),
    .CNT_W             (CW)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .events_i             (events),
    .dual_mode_i          (dual),
    .clr_cnt_i            (clr),
    .lane_ready_i         (ready),
    .lane_valid_o         (lane_valid),
    .lane_vector_o        (lane_vector),
    .lane_reset_o         (lane_reset),
    .lane_collision_cnt_o (coll_cnt),
    .drop_cnt_o           (drop_cnt)
  );

  typedef struct {
    logic [NL-1:0]         valid;
    logic [NL-1:0]         rst;
    logic [NL-1:0][VW-1:0] vec;
    logic [NL-1:0][CW-1:0] coll;
    logic [CW-1:0]         drop;
  } exp_t;

  exp_t          sb[$];
  bit            m_full[NL];
  logic [VW-1:0] m_buf[NL];
  int            m_coll[NL];
  bit            m_rst[NL];
  int            m_drop;
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic lane_ctrl mk(input int l0, input int l1, input int it,
                                  input bit pv, input bit rl, input bit two);
    lane_ctrl c;
    c.lane0      = RM_LANE_IDX_W'(l0);
    c.lane1      = RM_LANE_IDX_W'(l1);
    c.itype      = RM_ITYPE_W'(it);
    c.probe_val  = pv;
    c.reset_lane = rl;
    c.two_lane   = two;
    return c;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_full[l] = 0; m_buf[l] = '0; m_coll[l] = 0; m_rst[l] = 0;
    end
    m_drop = 0;
  endtask

  // Reference behaviour for one clock edge using the inputs held at that edge
  task automatic model_step();
    logic [VW-1:0] h[NL];
    bit            r[NL];
    bit            dropped;
    exp_t          e;
    dropped = 0;
    for (int l = 0; l < NL; l++) begin h[l] = '0; r[l] = 0; end
    for (int i = 0; i < NE; i++) begin
      int targets[$];
      if (events[i].probe_val || events[i].reset_lane) begin
        if (!events[i].two_lane) targets.push_back(int'(events[i].lane0));
        else begin
          targets.push_back(int'(events[i].lane1));
          if (dual) targets.push_back(int'(events[i].lane0));
        end
        foreach (targets[k]) begin
          if (targets[k] >= NL || int'(events[i].itype) >= NI) dropped = 1;
          else begin
            if (events[i].probe_val) h[targets[k]][int'(events[i].itype) * NE + i] = 1'b1;
            if (events[i].reset_lane) r[targets[k]] = 1;
          end
        end
      end
    end
    for (int l = 0; l < NL; l++) begin
      if (r[l]) begin
        m_full[l] = 0; m_buf[l] = '0;
      end else if (!m_full[l]) begin
        if (h[l] != 0) begin m_full[l] = 1; m_buf[l] = h[l]; end
      end else if (ready[l]) begin
        m_buf[l] = h[l]; m_full[l] = (h[l] != 0);
      end else begin
        if ((m_buf[l] & h[l]) != 0 && m_coll[l] < 255) m_coll[l]++;
        m_buf[l] = m_buf[l] | h[l];
      end
      m_rst[l] = r[l];
      if (clr) m_coll[l] = 0;
    end
    if (clr) m_drop = 0;
    else if (dropped && m_drop < 255) m_drop++;
    for (int l = 0; l < NL; l++) begin
      e.valid[l] = m_full[l];
      e.rst[l]   = m_rst[l];
      e.vec[l]   = m_buf[l];
      e.coll[l]  = CW'(m_coll[l]);
    end
    e.drop = CW'(m_drop);
    sb.push_back(e);
  endtask

  // One cycle: account for the edge just taken, then present the next inputs
  task automatic step(input lane_ctrl [NE-1:0] ev, input logic d, input logic c,
                      input logic [NL-1:0] rdy);
    @(posedge clk);
    #1;
    model_step();
    events = ev; dual = d; clr = c; ready = rdy;
  endtask

  // Monitor: compares every registered output against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("valid", 128'(lane_valid), 128'(e.valid));
        check("vector", 128'(lane_vector), 128'(e.vec));
        check("lane_reset", 128'(lane_reset), 128'(e.rst));
        check("coll_cnt", 128'(coll_cnt), 128'(e.coll));
        check("drop_cnt", 128'(drop_cnt), 128'(e.drop));
      end
    end
  end

  task automatic check_all_zero(input string nm);
    check({nm, "_valid"}, 128'(lane_valid), 128'(0));
    check({nm, "_vector"}, 128'(lane_vector), 128'(0));
    check({nm, "_reset"}, 128'(lane_reset), 128'(0));
    check({nm, "_coll"}, 128'(coll_cnt), 128'(0));
    check({nm, "_drop"}, 128'(drop_cnt), 128'(0));
  endtask

  lane_ctrl [NE-1:0] idle;
  lane_ctrl [NE-1:0] ev;
  lane_ctrl [NE-1:0] ev2;

  initial begin
    idle = '0;
    events = '0; dual = 1'b0; clr = 1'b0; ready = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single hit
    ev = '0; ev[3] = mk(2, 0, 1, 1, 0, 0);
    step(ev, 0, 0, '1);
    step(idle, 0, 0, '1);
    check("single_valid", 128'(lane_valid), 128'(5'b00100));
    check("single_vec", 128'(lane_vector[2][1]), 128'(10'h008));
    step(idle, 0, 0, '1);
    check("single_drain", 128'(lane_valid), 128'(0));

    // stall accumulation and collision
    ev = '0; ev[0] = mk(1, 0, 0, 1, 0, 0);
    ev2 = '0; ev2[4] = mk(1, 0, 0, 1, 0, 0);
    step(ev, 0, 0, 5'b11101);
    step(ev2, 0, 0, 5'b11101);
    step(ev, 0, 0, 5'b11101);
    step(idle, 0, 0, 5'b11101);
    check("stall_vec", 128'(lane_vector[1][0]), 128'(10'h011));
    check("stall_coll", 128'(coll_cnt[1]), 128'(1));
    step(idle, 0, 0, '1);
    check("stall_held", 128'(lane_valid[1]), 128'(1));
    step(idle, 0, 0, '1);
    check("stall_release", 128'(lane_valid[1]), 128'(0));

    // dual mode broadcast vs lane1-only
    ev = '0; ev[7] = mk(0, 3, 0, 1, 0, 1);
    step(ev, 1, 0, '1);
    step(idle, 1, 0, '1);
    check("dual_on", 128'(lane_valid), 128'(5'b01001));
    step(ev, 0, 0, '1);
    step(idle, 0, 0, '1);
    check("dual_off", 128'(lane_valid), 128'(5'b01000));
    step(idle, 0, 0, '1);

    // lane reset beats a stalled full buffer and a same-cycle hit
    ev = '0; ev[5] = mk(4, 0, 0, 1, 0, 0);
    ev2 = '0; ev2[5] = mk(4, 0, 0, 1, 1, 0);
    step(ev, 0, 0, 5'b01111);
    step(ev2, 0, 0, 5'b01111);
    step(idle, 0, 0, 5'b01111);
    check("rst_pulse", 128'(lane_reset), 128'(5'b10000));
    check("rst_valid", 128'(lane_valid[4]), 128'(0));
    check("rst_vec", 128'(lane_vector[4]), 128'(0));
    check("rst_coll", 128'(coll_cnt[4]), 128'(0));
    step(idle, 0, 0, '1);

    // out-of-range lane
    ev = '0; ev[2] = mk(6, 0, 0, 1, 0, 0);
    step(ev, 0, 0, '1);
    step(idle, 0, 0, '1);
    check("drop_cnt", 128'(drop_cnt), 128'(1));
    check("drop_valid", 128'(lane_valid), 128'(0));

    // collision counter saturation and clear
    ev = '0; ev[0] = mk(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 301; k++) step(ev, 0, 0, 5'b11110);
    step(idle, 0, 0, 5'b11110);
    check("sat_coll", 128'(coll_cnt[0]), 128'(255));
    step(idle, 0, 1, '1);
    step(idle, 0, 0, '1);
    check("clr_coll", 128'(coll_cnt[0]), 128'(0));
    check("clr_drop", 128'(drop_cnt), 128'(0));

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NE; i++) begin
        bit pv, rl;
        pv = ($urandom % 4) == 0;
        rl = ($urandom % 40) == 0;
        if (pv || rl) ev[i] = mk($urandom % 7, $urandom % 7, $urandom % 2, pv, rl, ($urandom % 3) == 0);
        else ev[i] = '0;
      end
      step(ev, 1'($urandom % 2), 1'(($urandom % 50) == 0), NL'($urandom));
    end

    // asynchronous reset in the middle of a stall
    ev = '0; ev[1] = mk(2, 0, 1, 1, 0, 0);
    step(ev, 0, 0, '0);
    step(idle, 0, 0, '0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async");
    model_reset();
    sb.delete();
    events = '0; dual = 1'b0; clr = 1'b0; ready = '1;
    @(negedge clk);
    rst_n = 1'b1;
    ev = '0; ev[9] = mk(3, 0, 0, 1, 0, 0);
    step(ev, 0, 0, '1);
    step(idle, 0, 0, '1);
    step(idle, 0, 0, '1);
    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
